// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin owner of a shared 4:1 mux.
// Registered one-hot grant, select and valid. Tenure is capped at MAX_HOLD
// cycles, and data_out is the selected lane gated by valid_out.
module rr_mux_arbiter #(
    parameter int unsigned DATA_W   = 1,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   data_in,
    output logic [3:0]            grant,
    output logic [1:0]            sel,
    output logic                  valid_out,
    output logic [DATA_W-1:0]     data_out
);

    localparam int unsigned CW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      last_q, last_d;
    logic [1:0]      sel_d;
    logic [3:0]      grant_d;
    logic            valid_d;

    logic [3:0][DATA_W-1:0] lane;
    logic [2:0]             pick;    // {found, index}
    logic                   rel;

    // First set request after 'base' in rotation order; base itself comes last.
    // In BUSY, base is the owner, so the owner is only re-picked when its req is
    // still high (expiry case).
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] c;
        rr_pick = '0;
        for (int k = 4; k >= 1; k--) begin
            c = base + 2'(k);
            if (r[c]) rr_pick = {1'b1, c};
        end
    endfunction

    // last_q tracks the owner while BUSY, so one search covers both states.
    assign pick = rr_pick(req, last_q);
    assign rel  = !req[sel] || (cnt_q == CW'(MAX_HOLD));

    // Unpack the flat lane bus.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign lane[i] = data_in[i*DATA_W +: DATA_W];
    end

    assign data_out = valid_out ? lane[sel] : '0;

    // State and registered outputs; reset wins over any tenure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant     <= '0;
            sel       <= '0;
            valid_out <= 1'b0;
            cnt_q     <= '0;
            last_q    <= 2'd3;
        end else begin
            state_q   <= state_d;
            grant     <= grant_d;
            sel       <= sel_d;
            valid_out <= valid_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
        end
    end

    // Next state: BUSY while someone owns the mux.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (pick[2]) state_d = BUSY;
            BUSY: if (rel && !pick[2]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next grant/select/counter; a release hands off on the same edge.
    always_comb begin
        grant_d = grant;
        sel_d   = sel;
        valid_d = valid_out;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (state_q == BUSY && !rel) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pick[2]) begin
            grant_d = 4'b0001 << pick[1:0];
            sel_d   = pick[1:0];
            valid_d = 1'b1;
            cnt_d   = CW'(1);
            last_d  = pick[1:0];
        end else begin
            // Idle: sel and last pointer keep their old values.
            grant_d = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (DATA_W=1, MAX_HOLD=8).
module tb_rr_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] data_in;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid_out;
    logic [0:0] data_out;

    int checks = 0;
    int errors = 0;

    rr_mux_arbiter #(.DATA_W(1), .MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .grant     (grant),
        .sel       (sel),
        .valid_out (valid_out),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Full output check; expected data is derived from the expected sel and valid.
    task automatic chk_out(input string tag, input logic [3:0] eg, input logic [1:0] es,
                           input logic ev);
        logic [3:0] ed;
        ed = ev ? {3'b000, data_in[es]} : 4'h0;
        chk({tag, ".grant"}, grant, eg);
        chk({tag, ".sel"},   {2'b00, sel}, {2'b00, es});
        chk({tag, ".valid"}, {3'b000, valid_out}, {3'b000, ev});
        chk({tag, ".data"},  {3'b000, data_out}, ed);
    endtask

    initial begin
        logic [3:0] m;
        // Reset held 2 cycles with all requests high.
        rst_n = 1'b0; req = 4'b1111; data_in = 4'b0101;
        tick(); tick();
        chk_out("reset", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_out("post_reset", 4'b0001, 2'd0, 1'b1);
        req = 4'b0000;
        tick();
        chk_out("post_reset_idle", 4'b0000, 2'd0, 1'b0);

        // Single requester 2.
        req = 4'b0100; data_in = 4'b0100;
        tick();
        chk_out("single", 4'b0100, 2'd2, 1'b1);
        req = 4'b0000;
        tick();
        chk_out("single_drop", 4'b0000, 2'd2, 1'b0);

        // Rotation 0,1,2,3,0 from a fresh reset.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        data_in = 4'b1010;
        req = 4'b1111;
        tick();
        chk_out("rot_first", 4'b0001, 2'd0, 1'b1);
        for (int o = 0; o < 4; o++) begin
            tick(); chk("rot_hold2", grant, 4'b0001 << o);
            tick(); chk("rot_hold3", grant, 4'b0001 << o);
            req = 4'b1111 & ~(4'b0001 << o);
            tick();
            m = 4'b0001 << ((o + 1) % 4);
            chk_out("rot_next", m, 2'((o + 1) % 4), 1'b1);
            req = 4'b1111;
        end
        req = 4'b0000;
        tick();

        // MAX_HOLD fairness between 0 and 1.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req = 4'b0011; data_in = 4'b0001;
        tick();
        chk_out("mh_0_start", 4'b0001, 2'd0, 1'b1);
        for (int i = 0; i < 7; i++) begin tick(); chk("mh_0_hold", grant, 4'b0001); end
        tick();
        chk_out("mh_1_start", 4'b0010, 2'd1, 1'b1);
        for (int i = 0; i < 7; i++) begin tick(); chk("mh_1_hold", grant, 4'b0010); end
        tick();
        chk_out("mh_0_again", 4'b0001, 2'd0, 1'b1);

        // Solo requester keeps the grant across expiry.
        req = 4'b0001;
        for (int i = 0; i < 20; i++) begin tick(); chk_out("solo", 4'b0001, 2'd0, 1'b1); end
        req = 4'b0000;
        tick();
        chk_out("solo_drop", 4'b0000, 2'd0, 1'b0);

        // Late arrival of requester 1 does not preempt owner 3.
        req = 4'b1000; data_in = 4'b1010;
        tick();
        chk_out("late_own3", 4'b1000, 2'd3, 1'b1);
        tick(); tick();
        req = 4'b1010;
        tick(); chk("late_nopre", grant, 4'b1000);
        tick(); chk("late_nopre", grant, 4'b1000);
        req = 4'b0010;
        tick();
        chk_out("late_hand", 4'b0010, 2'd1, 1'b1);

        // Reset mid-tenure at count 5, then counter restarts at 1.
        for (int i = 0; i < 4; i++) tick();
        chk("mid_cnt5", grant, 4'b0010);
        rst_n = 1'b0;
        tick();
        chk_out("mid_reset", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_out("mid_regrant", 4'b0010, 2'd1, 1'b1);
        req = 4'b0011;
        for (int i = 0; i < 7; i++) begin tick(); chk("mid_hold", grant, 4'b0010); end
        tick();
        chk_out("mid_expire", 4'b0001, 2'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares a single 4:1 multiplexer datapath between four requesters.
- Generates the 2-bit mux select, a one-hot grant vector and an output valid.
- Limits any one owner's tenure to MAX_HOLD cycles so no requester can starve the others.
- Sits directly in front of the shared 4:1 mux and drives its select.

Parameters:
- DATA_W, 1: width of each requester's data lane and of data_out.
- MAX_HOLD, 8: maximum consecutive granted cycles per tenure. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- req  input  4  request per requester; bit i held high while requester i wants the mux.
- data_in  input  4*DATA_W  packed lanes; lane i = data_in[i*DATA_W +: DATA_W].
- grant  output  4  one-hot grant (registered); all zero when idle.
- sel  output  2  mux select (registered); equals index of the set grant bit.
- valid_out  output  1  high while any grant is active (registered).
- data_out  output  DATA_W  lane[sel] when valid_out=1, else all zeros (combinational from registered sel).

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - grant=0, sel=0, valid_out=0, hold counter=0.
  - Last-granted pointer=3, so requester 0 has top priority after reset.
  - State=IDLE.
  - Reset overrides any active tenure in the same cycle.
- State IDLE:
  - If req!=0, grant the first set bit searching last+1, last+2, last+3, last (mod 4). Go to BUSY.
  - Grant latency: req seen at edge k gives grant/sel/valid_out at edge k+1. Counter loads 1.
  - If req==0, stay IDLE with outputs at reset values. sel retains its last value; data_out is gated to 0.
- State BUSY, owner = sel, evaluated each edge:
  - Release condition: req[owner]=0 OR counter==MAX_HOLD.
  - No release: keep the grant and increment the counter.
  - Release with other requests pending:
    - Hand off in the same edge to the next set bit in round-robin order starting at owner+1.
    - The owner itself is considered last, and only when its req is still high (MAX_HOLD expiry case).
    - Counter=1, last pointer=new owner, no bubble cycle.
  - Release with no requests pending: go to IDLE, grant=0, valid_out=0. Last pointer keeps the old owner.
  - MAX_HOLD expiry with only the owner requesting: re-grant the same owner, counter=1, grant stays high continuously.
- Invariants:
  - grant is always one-hot or zero.
  - valid_out == |grant.
  - sel == index of grant when valid_out=1.
  - The counter never exceeds MAX_HOLD.
  - Counter width = $clog2(MAX_HOLD+1).
- Requests arriving mid-tenure never preempt the owner. They are only considered at a release.
- A requester's req deasserting while it is not granted is legal; it is simply skipped.
- data_out has no added latency: same cycle as sel/valid_out.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req=4'b1111 → grant=0, sel=0, valid_out=0, data_out=0. Release reset → the next edge gives grant=4'b0001, sel=0.
- Single requester: req=4'b0100, data_in=4'b0100, DATA_W=1 → one edge later grant=4'b0100, sel=2, data_out=1. Drop req → the next edge gives grant=0, valid_out=0, data_out=0.
- Round-robin rotation: req=4'b1111, each owner drops req for 1 cycle after being granted 3 cycles → grant order 0,1,2,3,0 with no idle cycle between owners.
- MAX_HOLD fairness: MAX_HOLD=8, req=4'b0011 held constant → requester 0 holds exactly 8 cycles, then 1 for 8, then 0. Solo req=4'b0001 → grant stays 4'b0001 continuously across expiry.
- Late arrival, no preemption: requester 3 granted, req[1] rises mid-tenure → grant stays 4'b1000 until req[3] drops, then 4'b0010 on the following edge.
- Reset mid-tenure: grant=4'b0010 at count 5, rst_n=0 for one edge → grant=0. After release with req=4'b0010, grant returns to 4'b0010 with counter restarting at 1.
